// File: rtl/axi_lite_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_master_ctrl
// Description : AXI4-Lite initiator. Converts a one-at-a-time command port
//               into single-beat AXI writes/reads and reports completion on
//               a one-cycle rsp_* pulse. One transaction outstanding at most.
//               Optional handshake watchdog: define AXI_MASTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_master_ctrl #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic                    BVALID,
    output logic                    BREADY,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic                    RVALID,
    output logic                    RREADY
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_AW_W = 3'd1,
        S_WR_B    = 3'd2,
        S_RD_AR   = 3'd3,
        S_RD_R    = 3'd4
    } state_t;

    state_t                  r_state,     w_state_nxt;
    logic                    r_cmd_ready, w_cmd_ready_nxt;
    logic                    r_awvalid,   w_awvalid_nxt;
    logic                    r_wvalid,    w_wvalid_nxt;
    logic                    r_bready,    w_bready_nxt;
    logic                    r_arvalid,   w_arvalid_nxt;
    logic                    r_rready,    w_rready_nxt;
    logic                    r_aw_done,   w_aw_done_nxt;
    logic                    r_w_done,    w_w_done_nxt;
    logic                    r_rsp_valid, w_rsp_valid_nxt;
    logic                    r_rsp_write, w_rsp_write_nxt;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
    logic [ADDR_WIDTH-1:0]   r_awaddr,    w_awaddr_nxt;
    logic [DATA_WIDTH-1:0]   r_wdata,     w_wdata_nxt;
    logic [DATA_WIDTH/8-1:0] r_wstrb,     w_wstrb_nxt;
    logic [ADDR_WIDTH-1:0]   r_araddr,    w_araddr_nxt;

    // Channel handshakes, qualified by the registered VALID/READY we drive
    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    assign w_aw_hs = r_awvalid & AWREADY;
    assign w_w_hs  = r_wvalid  & WREADY;
    assign w_b_hs  = BVALID    & r_bready;
    assign w_ar_hs = r_arvalid & ARREADY;
    assign w_r_hs  = RVALID    & r_rready;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int                  c_WDOG_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [c_WDOG_W-1:0] r_wdog, w_wdog_nxt;
    logic                r_rsp_err, w_rsp_err_nxt;
    logic                w_wdog_expired;

    // Current cycle is the TIMEOUT_CYCLES-th spent in this non-idle state
    assign w_wdog_expired = (r_state != S_IDLE) && (r_wdog == c_WDOG_LAST);
    assign rsp_err        = r_rsp_err;
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;
    assign rsp_err = 1'b0;
`endif

    // Next-state and next-output logic; every output is registered
    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_ready_nxt = r_cmd_ready;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_aw_done_nxt   = r_aw_done;
        w_w_done_nxt    = r_w_done;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_write_nxt = r_rsp_write;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_awaddr_nxt    = r_awaddr;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_araddr_nxt    = r_araddr;
`ifdef AXI_MASTER_TIMEOUT_EN
        w_rsp_err_nxt   = 1'b0;
        w_wdog_nxt      = '0;
`endif
        case (r_state)
            S_IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_ready_nxt = 1'b0;
                    if (cmd_write) begin
                        w_state_nxt   = S_WR_AW_W;
                        w_awaddr_nxt  = cmd_addr;
                        w_wdata_nxt   = cmd_wdata;
                        w_wstrb_nxt   = cmd_wstrb;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_aw_done_nxt = 1'b0;
                        w_w_done_nxt  = 1'b0;
                    end else begin
                        w_state_nxt   = S_RD_AR;
                        w_araddr_nxt  = cmd_addr;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            S_WR_AW_W: begin
                // AW and W retire independently; leave once both have
                if (w_aw_hs) begin
                    w_awvalid_nxt = 1'b0;
                    w_aw_done_nxt = 1'b1;
                end
                if (w_w_hs) begin
                    w_wvalid_nxt = 1'b0;
                    w_w_done_nxt = 1'b1;
                end
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_nxt  = S_WR_B;
                    w_bready_nxt = 1'b1;
                end
            end
            S_WR_B: begin
                if (w_b_hs) begin
                    w_bready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_write_nxt = 1'b1;
                    w_cmd_ready_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
            end
            S_RD_AR: begin
                if (w_ar_hs) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = S_RD_R;
                end
            end
            S_RD_R: begin
                if (w_r_hs) begin
                    w_rready_nxt    = 1'b0;
                    w_rsp_rdata_nxt = RDATA;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_write_nxt = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
`ifdef AXI_MASTER_TIMEOUT_EN
        // A state change on the limit cycle means a handshake completed; it wins
        if (w_wdog_expired && (w_state_nxt == r_state)) begin
            w_awvalid_nxt   = 1'b0;
            w_wvalid_nxt    = 1'b0;
            w_bready_nxt    = 1'b0;
            w_arvalid_nxt   = 1'b0;
            w_rready_nxt    = 1'b0;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_write_nxt = (r_state == S_WR_AW_W) || (r_state == S_WR_B);
            w_cmd_ready_nxt = 1'b1;
            w_state_nxt     = S_IDLE;
        end
        if ((r_state != S_IDLE) && (w_state_nxt == r_state)) begin
            w_wdog_nxt = r_wdog + 1'b1;
        end
`endif
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_araddr    <= '0;
`ifdef AXI_MASTER_TIMEOUT_EN
            r_wdog      <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_aw_done   <= w_aw_done_nxt;
            r_w_done    <= w_w_done_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_write <= w_rsp_write_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_awaddr    <= w_awaddr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_araddr    <= w_araddr_nxt;
`ifdef AXI_MASTER_TIMEOUT_EN
            r_wdog      <= w_wdog_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
`endif
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = (r_state != S_IDLE);
    assign AWADDR    = r_awaddr;
    assign AWVALID   = r_awvalid;
    assign WDATA     = r_wdata;
    assign WSTRB     = r_wstrb;
    assign WVALID    = r_wvalid;
    assign BREADY    = r_bready;
    assign ARADDR    = r_araddr;
    assign ARVALID   = r_arvalid;
    assign RREADY    = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_master_ctrl
// Description : Bench for axi_lite_master_ctrl paired with a behavioural
//               4x32b AXI4-Lite register slave with programmable stalls.
//               Timeout scenario runs when AXI_MASTER_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master_ctrl;

    typedef struct packed {
        logic        wr;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [3:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        cmd_ready, rsp_valid, rsp_write, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic [3:0]  AWADDR, ARADDR, WSTRB;
    logic [31:0] WDATA, RDATA;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;

    int   n_checks = 0;
    int   n_err    = 0;
    rsp_t exp_q[$];
    rsp_t act_q[$];

    // Reference model of the slave register file and the held read data
    logic [31:0] m_mem [4];
    logic [31:0] m_last_rd = '0;

    // Slave stall knobs
    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    bit ar_block = 1'b0;

    axi_lite_master_ctrl #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    // Behavioural register slave: READY only after seeing VALID
    logic [31:0] s_mem [4];
    logic        s_aw_got, s_w_got, s_ar_got;
    logic [3:0]  s_awaddr, s_araddr, s_wstrb;
    logic [31:0] s_wdata;
    int          s_awc, s_wc, s_bc, s_arc, s_rc;
    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            AWREADY <= 1'b0; WREADY <= 1'b0; BVALID <= 1'b0;
            ARREADY <= 1'b0; RVALID <= 1'b0; RDATA  <= '0;
            s_aw_got <= 1'b0; s_w_got <= 1'b0; s_ar_got <= 1'b0;
            s_awaddr <= '0; s_araddr <= '0; s_wstrb <= '0; s_wdata <= '0;
            s_awc <= 0; s_wc <= 0; s_bc <= 0; s_arc <= 0; s_rc <= 0;
            for (int k = 0; k < 4; k++) s_mem[k] <= '0;
        end else begin
            if (AWVALID && AWREADY) begin
                AWREADY <= 1'b0; s_aw_got <= 1'b1; s_awaddr <= AWADDR; s_awc <= 0;
            end else if (AWVALID && !s_aw_got) begin
                if (s_awc >= aw_delay) AWREADY <= 1'b1; else s_awc <= s_awc + 1;
            end
            if (WVALID && WREADY) begin
                WREADY <= 1'b0; s_w_got <= 1'b1; s_wdata <= WDATA; s_wstrb <= WSTRB; s_wc <= 0;
            end else if (WVALID && !s_w_got) begin
                if (s_wc >= w_delay) WREADY <= 1'b1; else s_wc <= s_wc + 1;
            end
            if (BVALID && BREADY) begin
                BVALID <= 1'b0; s_aw_got <= 1'b0; s_w_got <= 1'b0; s_bc <= 0;
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) s_mem[s_awaddr[3:2]][8*b +: 8] <= s_wdata[8*b +: 8];
            end else if (s_aw_got && s_w_got && !BVALID) begin
                if (s_bc >= b_delay) BVALID <= 1'b1; else s_bc <= s_bc + 1;
            end
            if (ARVALID && ARREADY) begin
                ARREADY <= 1'b0; s_ar_got <= 1'b1; s_araddr <= ARADDR; s_arc <= 0;
            end else if (ARVALID && !s_ar_got && !ar_block) begin
                if (s_arc >= ar_delay) ARREADY <= 1'b1; else s_arc <= s_arc + 1;
            end
            if (RVALID && RREADY) begin
                RVALID <= 1'b0; s_ar_got <= 1'b0; s_rc <= 0;
            end else if (s_ar_got && !RVALID) begin
                if (s_rc >= r_delay) begin
                    RVALID <= 1'b1; RDATA <= s_mem[s_araddr[3:2]];
                end else s_rc <= s_rc + 1;
            end
        end
    end

    // Collect every response pulse observed by the bench
    always @(negedge ACLK) begin
        if (ARESETn && rsp_valid) act_q.push_back(rsp_t'({rsp_write, rsp_err, rsp_rdata}));
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "bench timeout");
    end

    // Drive one command, wait for acceptance, push the modelled response
    task automatic issue_cmd(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic exp_err);
        int   t;
        rsp_t e;
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        t = 0;
        while (!cmd_ready && t < 200) begin @(negedge ACLK); t++; end
        if (!cmd_ready) begin
            n_checks++; n_err++;
            $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, t);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge ACLK);
        #1 cmd_valid = 1'b0;
        if (exp_err) begin
            e = '{wr: wr, err: 1'b1, rdata: m_last_rd};
        end else if (wr) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_mem[addr[3:2]][8*b +: 8] = data[8*b +: 8];
            e = '{wr: 1'b1, err: 1'b0, rdata: m_last_rd};
        end else begin
            m_last_rd = m_mem[addr[3:2]];
            e = '{wr: 1'b0, err: 1'b0, rdata: m_last_rd};
        end
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({cmd_ready, busy, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_write, rsp_err} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b, required all zero",
                     {cmd_ready, busy, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_write, rsp_err});
        end
        n_checks++;
        if ({AWADDR, WDATA, WSTRB, ARADDR, rsp_rdata} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h, required 0", {AWADDR, WDATA, WSTRB, ARADDR, rsp_rdata});
        end
        @(negedge ACLK); ARESETn = 1'b1;
        repeat (2) @(negedge ACLK);
        n_checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_idle: cmd_ready,busy=%b, required 10", {cmd_ready, busy});
        end
    endtask

    task automatic test_write_read();
        int t; rsp_t a, e;
        issue_cmd(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 1'b0);
        issue_cmd(1'b0, 4'h4, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            t = 0;
            while (act_q.size() == 0 && t < 100) begin @(negedge ACLK); t++; end
            n_checks++;
            e = exp_q.pop_front();
            if (act_q.size() == 0) begin
                n_err++; $display("FAIL wr_rd_rsp%0d: no response, required %h", i, e);
            end else begin
                a = act_q.pop_front();
                if (a !== e) begin
                    n_err++;
                    $display("FAIL wr_rd_rsp%0d: got wr=%b err=%b rdata=%h, required wr=%b err=%b rdata=%h",
                             i, a.wr, a.err, a.rdata, e.wr, e.err, e.rdata);
                end
            end
        end
        n_checks++;
        if (rsp_rdata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL wr_rd_hold: rsp_rdata=%h, required deadbeef", rsp_rdata);
        end
    endtask

    task automatic test_strobe();
        int t; rsp_t a, e;
        issue_cmd(1'b1, 4'h8, 32'hFFFFFFFF, 4'hF, 1'b0);
        issue_cmd(1'b1, 4'h8, 32'h00000000, 4'h5, 1'b0);
        issue_cmd(1'b0, 4'h8, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            t = 0;
            while (act_q.size() == 0 && t < 100) begin @(negedge ACLK); t++; end
            n_checks++;
            e = exp_q.pop_front();
            if (act_q.size() == 0) begin
                n_err++; $display("FAIL strobe_rsp%0d: no response, required %h", i, e);
            end else begin
                a = act_q.pop_front();
                if (a !== e) begin
                    n_err++;
                    $display("FAIL strobe_rsp%0d: got wr=%b err=%b rdata=%h, required wr=%b err=%b rdata=%h",
                             i, a.wr, a.err, a.rdata, e.wr, e.err, e.rdata);
                end
            end
        end
        n_checks++;
        if (rsp_rdata !== 32'hFF00FF00) begin
            n_err++; $display("FAIL strobe_data: rsp_rdata=%h, required ff00ff00", rsp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int t, c0, c1; rsp_t a, e;
        logic [31:0] pat [4];
        pat[0] = 32'h11111111; pat[1] = 32'h22222222; pat[2] = 32'h33333333; pat[3] = 32'h44444444;
        c0 = 0;
        fork
            begin forever begin @(posedge ACLK); c0++; end end
            begin
                for (int i = 0; i < 4; i++) issue_cmd(1'b1, 4'(i * 4), pat[i], 4'hF, 1'b0);
                for (int i = 0; i < 4; i++) issue_cmd(1'b0, 4'(i * 4), 32'h0, 4'h0, 1'b0);
                t = 0;
                while (act_q.size() < 8 && t < 100) begin @(negedge ACLK); t++; end
            end
        join_any
        disable fork;
        c1 = c0;
        // five cycles per command with this slave, plus edge-alignment slack
        n_checks++;
        if (c1 > 44) begin
            n_err++; $display("FAIL b2b_cycles: took %0d cycles, required <= 44", c1);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            e = exp_q.pop_front();
            if (act_q.size() == 0) begin
                n_err++; $display("FAIL b2b_rsp%0d: no response, required %h", i, e);
            end else begin
                a = act_q.pop_front();
                if (a !== e) begin
                    n_err++;
                    $display("FAIL b2b_rsp%0d: got wr=%b err=%b rdata=%h, required wr=%b err=%b rdata=%h",
                             i, a.wr, a.err, a.rdata, e.wr, e.err, e.rdata);
                end
            end
        end
        repeat (10) @(negedge ACLK);
        n_checks++;
        if (act_q.size() != 0) begin
            n_err++; $display("FAIL b2b_extra: %0d extra responses, required 0", act_q.size());
        end
    endtask

    task automatic test_stall();
        int t, cyc, aw_c, w_c; rsp_t a, e;
        logic p_aw, p_w, p_ar;
        aw_delay = 0; w_delay = 3; b_delay = 5;
        issue_cmd(1'b1, 4'hC, 32'h12345678, 4'hF, 1'b0);
        n_checks++;
        if ({AWVALID, WVALID} !== 2'b11) begin
            n_err++; $display("FAIL stall_valid_lat: AWVALID,WVALID=%b, required 11", {AWVALID, WVALID});
        end
        p_aw = 1'b0; p_w = 1'b0; cyc = 0; aw_c = -1; w_c = -1;
        while (act_q.size() == 0 && cyc < 40) begin
            @(negedge ACLK); cyc++;
            if (p_aw) begin
                n_checks++;
                if (!AWVALID || AWADDR !== 4'hC) begin
                    n_err++; $display("FAIL stall_aw_stable: AWVALID=%b AWADDR=%h, required 1 c", AWVALID, AWADDR);
                end
            end
            if (p_w) begin
                n_checks++;
                if (!WVALID || WDATA !== 32'h12345678 || WSTRB !== 4'hF) begin
                    n_err++; $display("FAIL stall_w_stable: WVALID=%b WDATA=%h WSTRB=%h, required 1 12345678 f",
                                      WVALID, WDATA, WSTRB);
                end
            end
            if (AWVALID && AWREADY) aw_c = cyc;
            if (WVALID && WREADY) w_c = cyc;
            p_aw = AWVALID && !AWREADY;
            p_w  = WVALID && !WREADY;
        end
        n_checks++;
        if (w_c - aw_c != 3) begin
            n_err++; $display("FAIL stall_order: W-AW handshake gap %0d cycles, required 3", w_c - aw_c);
        end
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 2; r_delay = 3;
        issue_cmd(1'b0, 4'hC, 32'h0, 4'h0, 1'b0);
        p_ar = 1'b0; cyc = 0;
        while (act_q.size() < 2 && cyc < 40) begin
            @(negedge ACLK); cyc++;
            if (p_ar) begin
                n_checks++;
                if (!ARVALID || ARADDR !== 4'hC) begin
                    n_err++; $display("FAIL stall_ar_stable: ARVALID=%b ARADDR=%h, required 1 c", ARVALID, ARADDR);
                end
            end
            p_ar = ARVALID && !ARREADY;
        end
        ar_delay = 0; r_delay = 0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            e = exp_q.pop_front();
            if (act_q.size() == 0) begin
                n_err++; $display("FAIL stall_rsp%0d: no response, required %h", i, e);
            end else begin
                a = act_q.pop_front();
                if (a !== e) begin
                    n_err++;
                    $display("FAIL stall_rsp%0d: got wr=%b err=%b rdata=%h, required wr=%b err=%b rdata=%h",
                             i, a.wr, a.err, a.rdata, e.wr, e.err, e.rdata);
                end
            end
        end
        repeat (10) @(negedge ACLK);
        n_checks++;
        if (act_q.size() != 0) begin
            n_err++; $display("FAIL stall_extra: %0d extra responses, required 0", act_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int t, n_before; rsp_t a, e;
        b_delay = 10;
        issue_cmd(1'b1, 4'h4, 32'hA5A55A5A, 4'hF, 1'b0);
        t = 0;
        while (!BREADY && t < 50) begin @(negedge ACLK); t++; end
        n_checks++;
        if (!BREADY) begin
            n_err++; $display("FAIL rstmid_reach_wrb: BREADY=%b, required 1", BREADY);
        end
        n_before = act_q.size();
        #2 ARESETn = 1'b0;
        #1;
        n_checks++;
        if ({cmd_ready, busy, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_write} !== 9'b0) begin
            n_err++;
            $display("FAIL rstmid_ctrl: got %b, required all zero",
                     {cmd_ready, busy, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_write});
        end
        n_checks++;
        if ({AWADDR, WDATA, WSTRB, ARADDR, rsp_rdata} !== '0) begin
            n_err++; $display("FAIL rstmid_data: got %h, required 0", {AWADDR, WDATA, WSTRB, ARADDR, rsp_rdata});
        end
        b_delay = 0;
        repeat (3) @(negedge ACLK);
        ARESETn = 1'b1;
        repeat (10) @(negedge ACLK);
        n_checks++;
        if (act_q.size() != n_before) begin
            n_err++; $display("FAIL rstmid_no_rsp: %0d responses, required %0d", act_q.size(), n_before);
        end
        exp_q.delete(); act_q.delete();
        for (int k = 0; k < 4; k++) m_mem[k] = '0;
        m_last_rd = '0;
        issue_cmd(1'b0, 4'h4, 32'h0, 4'h0, 1'b0);
        issue_cmd(1'b1, 4'h4, 32'h600DF00D, 4'hF, 1'b0);
        issue_cmd(1'b0, 4'h4, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            t = 0;
            while (act_q.size() == 0 && t < 100) begin @(negedge ACLK); t++; end
            n_checks++;
            e = exp_q.pop_front();
            if (act_q.size() == 0) begin
                n_err++; $display("FAIL rstmid_rsp%0d: no response, required %h", i, e);
            end else begin
                a = act_q.pop_front();
                if (a !== e) begin
                    n_err++;
                    $display("FAIL rstmid_rsp%0d: got wr=%b err=%b rdata=%h, required wr=%b err=%b rdata=%h",
                             i, a.wr, a.err, a.rdata, e.wr, e.err, e.rdata);
                end
            end
        end
    endtask

`ifdef AXI_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int cyc, t; rsp_t a, e;
        ar_block = 1'b1;
        issue_cmd(1'b0, 4'h0, 32'h0, 4'h0, 1'b1);
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin @(posedge ACLK); #1; cyc++; end
        n_checks++;
        if (cyc != 8) begin
            n_err++; $display("FAIL timeout_cycles: rsp after %0d cycles, required 8", cyc);
        end
        n_checks++;
        if ({rsp_valid, rsp_err, ARVALID} !== 3'b110) begin
            n_err++; $display("FAIL timeout_flags: rsp_valid,rsp_err,ARVALID=%b, required 110",
                              {rsp_valid, rsp_err, ARVALID});
        end
        ar_block = 1'b0;
        t = 0;
        while (act_q.size() == 0 && t < 10) begin @(negedge ACLK); t++; end
        n_checks++;
        e = exp_q.pop_front();
        if (act_q.size() == 0) begin
            n_err++; $display("FAIL timeout_rsp: no response, required %h", e);
        end else begin
            a = act_q.pop_front();
            if (a !== e) begin
                n_err++;
                $display("FAIL timeout_rsp: got wr=%b err=%b rdata=%h, required wr=%b err=%b rdata=%h",
                         a.wr, a.err, a.rdata, e.wr, e.err, e.rdata);
            end
        end
    endtask
`endif

    initial begin
        for (int k = 0; k < 4; k++) m_mem[k] = '0;
        repeat (3) @(negedge ACLK);
        test_reset();
        test_write_read();
        test_strobe();
        test_back_to_back();
        test_stall();
        test_reset_mid();
`ifdef AXI_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        repeat (5) @(negedge ACLK);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
